// File: rtl/posit_mult_checker_if.sv
// Stream bundle between the expected-value source, the posit multiplier
// output and the result checker.
interface posit_mult_checker_if #(
  parameter int N = 32
);
  logic         exp_valid;
  logic [N-1:0] exp_data;
  logic         exp_ready;
  logic         res_valid;
  logic [N-1:0] res_data;

  modport master (
    output exp_valid,
    output exp_data,
    output res_valid,
    output res_data,
    input  exp_ready
  );

  modport slave (
    input  exp_valid,
    input  exp_data,
    input  res_valid,
    input  res_data,
    output exp_ready
  );
endinterface

// File: rtl/posit_mult_checker.sv
// On-hardware result checker for positmult: queues expected products, pairs
// each multiplier result with the oldest one and keeps pass/fail statistics.
module posit_mult_checker #(
  parameter int           N     = 32,
  parameter int           DEPTH = 16,
  parameter logic [N-1:0] TOL   = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   finish,
  posit_mult_checker_if.slave    bus,
  output logic                   cmp_valid,
  output logic                   cmp_pass,
  output logic [N-1:0]           cmp_diff,
  output logic [31:0]            cmp_index,
  output logic [31:0]            pass_count,
  output logic [31:0]            fail_count,
  output logic [N-1:0]           max_diff,
  output logic                   orphan,
  output logic                   overflow,
  output logic                   check_done
);

  localparam int           AW   = $clog2(DEPTH);
  localparam logic [AW:0]  FULL = DEPTH[AW:0];
  localparam logic [N-1:0] NAR  = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state;
  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          stg_valid;
  logic [N-1:0]  stg_exp;
  logic [N-1:0]  stg_res;
  logic [31:0]   seq;

  logic          active;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [N-1:0]  diff;
  logic          pass;

  // A start pulse flushes everything, so no push or pop is honoured in that cycle.
  assign active        = (state == RUN) || (state == DRAIN);
  assign fifo_empty    = (count == '0);
  assign bus.exp_ready = (state == RUN) && (count != FULL);
  assign push          = bus.exp_valid && bus.exp_ready && !start;
  assign pop           = bus.res_valid && active && !fifo_empty && !start;

  // NaR only ever matches itself, regardless of the tolerance window.
  always_comb begin
    diff = (stg_exp > stg_res) ? (stg_exp - stg_res) : (stg_res - stg_exp);
    if ((stg_exp == NAR) || (stg_res == NAR)) begin
      pass = (stg_exp == stg_res);
    end else begin
      pass = (diff <= TOL);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.exp_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      stg_valid  <= 1'b0;
      stg_exp    <= '0;
      stg_res    <= '0;
      seq        <= '0;
      cmp_valid  <= 1'b0;
      cmp_pass   <= 1'b0;
      cmp_diff   <= '0;
      cmp_index  <= '0;
      pass_count <= '0;
      fail_count <= '0;
      max_diff   <= '0;
      orphan     <= 1'b0;
      overflow   <= 1'b0;
      check_done <= 1'b0;
    end else if (start) begin
      state      <= RUN;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      stg_valid  <= 1'b0;
      seq        <= '0;
      cmp_valid  <= 1'b0;
      cmp_pass   <= 1'b0;
      cmp_diff   <= '0;
      cmp_index  <= '0;
      pass_count <= '0;
      fail_count <= '0;
      max_diff   <= '0;
      orphan     <= 1'b0;
      overflow   <= 1'b0;
      check_done <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end

      stg_valid <= pop;
      if (pop) begin
        stg_exp <= mem[rd_ptr];
        stg_res <= bus.res_data;
      end

      // Retire the staged comparison into the reported outputs and statistics.
      cmp_valid <= stg_valid;
      if (stg_valid) begin
        cmp_pass  <= pass;
        cmp_diff  <= diff;
        cmp_index <= seq;
        seq       <= seq + 1'b1;
        if (pass) begin
          if (pass_count != '1) begin
            pass_count <= pass_count + 1'b1;
          end
        end else begin
          if (fail_count != '1) begin
            fail_count <= fail_count + 1'b1;
          end
        end
        if (diff > max_diff) begin
          max_diff <= diff;
        end
      end

      if (bus.res_valid && active && fifo_empty) begin
        orphan <= 1'b1;
      end
      if (bus.exp_valid && (state == RUN) && (count == FULL)) begin
        overflow <= 1'b1;
      end

      case (state)
        RUN: begin
          if (finish) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty && !stg_valid) begin
            state      <= DONE;
            check_done <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_posit_mult_checker.sv
// Self-checking bench for posit_mult_checker: directed vector table, corner
// sequences and a randomized run against a queue-based reference model.
module tb_posit_mult_checker;

  localparam int          N     = 32;
  localparam int          DEPTH = 16;
  localparam logic [31:0] TOL   = 32'd1;
  localparam logic [31:0] NAR   = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        finish = 1'b0;
  logic        cmp_valid;
  logic        cmp_pass;
  logic [31:0] cmp_diff;
  logic [31:0] cmp_index;
  logic [31:0] pass_count;
  logic [31:0] fail_count;
  logic [31:0] max_diff;
  logic        orphan;
  logic        overflow;
  logic        check_done;

  posit_mult_checker_if #(.N(N)) bus ();

  posit_mult_checker #(.N(N), .DEPTH(DEPTH), .TOL(TOL)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .finish     (finish),
    .bus        (bus),
    .cmp_valid  (cmp_valid),
    .cmp_pass   (cmp_pass),
    .cmp_diff   (cmp_diff),
    .cmp_index  (cmp_index),
    .pass_count (pass_count),
    .fail_count (fail_count),
    .max_diff   (max_diff),
    .orphan     (orphan),
    .overflow   (overflow),
    .check_done (check_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: a plain queue of outstanding expected values plus the
  // one comparison that is waiting a cycle before it is reported.
  typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_DONE} mstate_t;
  mstate_t     m_state;
  logic [31:0] q[$];
  logic        pend_valid;
  logic [31:0] pend_e, pend_r;
  logic        m_cmp_valid, m_pass;
  logic [31:0] m_diff, m_index, m_seq, m_pass_cnt, m_fail_cnt, m_max;
  logic        m_orphan, m_ovf, m_done;

  typedef struct {
    logic [31:0] e;
    logic [31:0] r;
    logic        pass;
    logic [31:0] diff;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic void ref_compare(input logic [31:0] e, input logic [31:0] r,
                                      output logic p, output logic [31:0] d);
    longint delta;
    delta = longint'(e) - longint'(r);
    if (delta < 0) delta = -delta;
    d = delta[31:0];
    if ((e == NAR) || (r == NAR)) p = (e == r);
    else p = (delta <= longint'(TOL));
  endfunction

  function automatic void model_clear(input mstate_t s);
    q.delete();
    pend_valid = 1'b0; pend_e = '0; pend_r = '0;
    m_cmp_valid = 1'b0; m_pass = 1'b0; m_diff = '0; m_index = '0; m_seq = '0;
    m_pass_cnt = '0; m_fail_cnt = '0; m_max = '0;
    m_orphan = 1'b0; m_ovf = 1'b0; m_done = 1'b0;
    m_state = s;
  endfunction

  function automatic void model_edge();
    logic        active, ready, was_empty, was_pend, p;
    logic [31:0] d;
    active    = (m_state == M_RUN) || (m_state == M_DRAIN);
    ready     = (m_state == M_RUN) && (q.size() < DEPTH);
    was_empty = (q.size() == 0);
    was_pend  = pend_valid;
    if (start) begin
      model_clear(M_RUN);
      return;
    end
    m_cmp_valid = pend_valid;
    if (pend_valid) begin
      ref_compare(pend_e, pend_r, p, d);
      m_pass  = p;
      m_diff  = d;
      m_index = m_seq;
      m_seq   = m_seq + 1;
      if (p && m_pass_cnt != 32'hFFFF_FFFF) m_pass_cnt = m_pass_cnt + 1;
      if (!p && m_fail_cnt != 32'hFFFF_FFFF) m_fail_cnt = m_fail_cnt + 1;
      if (d > m_max) m_max = d;
    end
    pend_valid = 1'b0;
    if (bus.res_valid && active) begin
      if (!was_empty) begin
        pend_valid = 1'b1;
        pend_e     = q.pop_front();
        pend_r     = bus.res_data;
      end else begin
        m_orphan = 1'b1;
      end
    end
    if (bus.exp_valid) begin
      if (ready) q.push_back(bus.exp_data);
      else if (m_state == M_RUN) m_ovf = 1'b1;
    end
    if (m_state == M_RUN && finish) m_state = M_DRAIN;
    else if (m_state == M_DRAIN && was_empty && !was_pend) m_state = M_DONE;
    m_done = (m_state == M_DONE);
  endfunction

  task automatic check_output();
    logic m_ready;
    m_ready = (m_state == M_RUN) && (q.size() < DEPTH);
    chk("exp_ready", 32'(bus.exp_ready), 32'(m_ready));
    chk("cmp_valid", 32'(cmp_valid), 32'(m_cmp_valid));
    if (m_cmp_valid) begin
      chk("cmp_pass", 32'(cmp_pass), 32'(m_pass));
      chk("cmp_diff", cmp_diff, m_diff);
      chk("cmp_index", cmp_index, m_index);
    end
    chk("pass_count", pass_count, m_pass_cnt);
    chk("fail_count", fail_count, m_fail_cnt);
    chk("max_diff", max_diff, m_max);
    chk("orphan", 32'(orphan), 32'(m_orphan));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("check_done", 32'(check_done), 32'(m_done));
  endtask

  task automatic check_reset_values();
    chk("rst_exp_ready", 32'(bus.exp_ready), 32'd0);
    chk("rst_cmp_valid", 32'(cmp_valid), 32'd0);
    chk("rst_cmp_pass", 32'(cmp_pass), 32'd0);
    chk("rst_cmp_diff", cmp_diff, 32'd0);
    chk("rst_cmp_index", cmp_index, 32'd0);
    chk("rst_pass_count", pass_count, 32'd0);
    chk("rst_fail_count", fail_count, 32'd0);
    chk("rst_max_diff", max_diff, 32'd0);
    chk("rst_orphan", 32'(orphan), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_check_done", 32'(check_done), 32'd0);
  endtask

  task automatic apply_stimulus(input logic s, input logic f, input logic ev,
                                input logic [31:0] ed, input logic rv, input logic [31:0] rd);
    start = s; finish = f;
    bus.exp_valid = ev; bus.exp_data = ed;
    bus.res_valid = rv; bus.res_data = rd;
    model_edge();
    @(posedge clk);
    #1;
    check_output();
    start = 1'b0; finish = 1'b0;
    bus.exp_valid = 1'b0; bus.res_valid = 1'b0;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic push(input logic [31:0] v);
    apply_stimulus(1'b0, 1'b0, 1'b1, v, 1'b0, 32'd0);
  endtask

  task automatic result(input logic [31:0] v);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, v);
  endtask

  // Feeds matching results until DONE or the cycle budget runs out.
  task automatic wait_done(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (check_done) break;
      if (q.size() > 0) result(q[0]);
      else idle();
    end
    chk("check_done_timeout", 32'(check_done), 32'd1);
  endtask

  function automatic logic [31:0] pick_value();
    case ($urandom_range(0, 5))
      0: return NAR;
      1: return 32'd0;
      2: return 32'h4000_0000 + 32'($urandom_range(0, 3));
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int expect_fail;
    logic [31:0] rd;

    tbl[0] = '{32'h4000_0002, 32'h4000_0001, 1'b1, 32'd1};
    tbl[1] = '{32'h4000_0002, 32'h4000_0005, 1'b0, 32'd3};
    tbl[2] = '{32'h8000_0000, 32'h8000_0001, 1'b0, 32'd1};
    tbl[3] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'd0};
    tbl[4] = '{32'h0000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000};
    tbl[5] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 32'd1};
    tbl[6] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF};
    tbl[7] = '{32'h0000_0005, 32'h0000_0006, 1'b1, 32'd1};
    tbl[8] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'd0};

    bus.exp_valid = 1'b0; bus.exp_data = '0;
    bus.res_valid = 1'b0; bus.res_data = '0;
    model_clear(M_IDLE);
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    @(negedge clk) reset = 1'b0;

    $display("[TB] basic match");
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    push(32'h4000_0000);
    push(32'h4800_0000);
    result(32'h4000_0000);
    result(32'h4800_0000);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    wait_done(20);
    chk("basic_pass_count", pass_count, 32'd2);
    chk("basic_fail_count", fail_count, 32'd0);
    chk("basic_max_diff", max_diff, 32'd0);

    $display("[TB] vector table");
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    expect_fail = 0;
    for (int i = 0; i < 9; i++) begin
      push(tbl[i].e);
      result(tbl[i].r);
      idle();
      chk("tbl_cmp_valid", 32'(cmp_valid), 32'd1);
      chk("tbl_cmp_pass", 32'(cmp_pass), 32'(tbl[i].pass));
      chk("tbl_cmp_diff", cmp_diff, tbl[i].diff);
      chk("tbl_cmp_index", cmp_index, 32'(i));
      if (!tbl[i].pass) expect_fail++;
      if (i == 1) chk("tol_max_diff", max_diff, 32'd3);
    end
    chk("tbl_fail_count", fail_count, 32'(expect_fail));
    chk("tbl_max_diff", max_diff, 32'hFFFF_FFFF);

    $display("[TB] full and overflow");
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      push(32'h1000_0000 + 32'(i));
      if (i == DEPTH - 2) chk("ready_at_15", 32'(bus.exp_ready), 32'd1);
    end
    chk("ready_at_16", 32'(bus.exp_ready), 32'd0);
    push(32'hDEAD_BEEF);
    chk("overflow_17th", 32'(overflow), 32'd1);
    result(q[0]);
    chk("ready_after_pop", 32'(bus.exp_ready), 32'd1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h2000_0000, 1'b1, q[0]);
    chk("ready_after_pushpop", 32'(bus.exp_ready), 32'd1);
    push(32'h2000_0001);
    chk("ready_refilled", 32'(bus.exp_ready), 32'd0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    wait_done(40);

    $display("[TB] orphan");
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    result(32'h0000_1234);
    chk("orphan_set", 32'(orphan), 32'd1);
    chk("orphan_pass_count", pass_count, 32'd0);
    chk("orphan_fail_count", fail_count, 32'd0);
    idle();
    chk("orphan_no_cmp", 32'(cmp_valid), 32'd0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h4000_0000, 1'b1, 32'h4000_0000);
    result(32'h4000_0000);
    idle();
    chk("orphan_stored_cmp", 32'(cmp_valid), 32'd1);
    chk("orphan_stored_index", cmp_index, 32'd0);

    $display("[TB] reset mid-run and restart");
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    for (int i = 0; i < 6; i++) push(32'h3000_0000 + 32'(i));
    result(q[0]);
    reset = 1'b1;
    #2;
    model_clear(M_IDLE);
    check_reset_values();
    @(negedge clk) reset = 1'b0;
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    push(32'h5000_0000);
    result(32'h5000_0000);
    idle();
    chk("restart_cmp_valid", 32'(cmp_valid), 32'd1);
    chk("restart_cmp_index", cmp_index, 32'd0);
    chk("restart_pass_count", pass_count, 32'd1);

    $display("[TB] randomized run");
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    for (int c = 0; c < 1500; c++) begin
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        rd = q[0] + 32'($urandom_range(0, 2)) - 32'd1;
      else
        rd = pick_value();
      apply_stimulus(($urandom_range(0, 299) == 0), 1'b0,
                     1'($urandom_range(0, 1)), pick_value(),
                     1'($urandom_range(0, 1)), rd);
    end
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    wait_done(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
